// File: rtl/led_cfg_if.sv
// Config port bundle for led_pattern_ctrl: valid/ready write of one channel's mode/duty.
// Ports: cfg_valid, cfg_ch, cfg_mode, cfg_duty (master->slave); cfg_ready (slave->master).
interface led_cfg_if #(
  parameter int CH_W  = 2,
  parameter int PWM_W = 4
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_mode;
  logic [PWM_W-1:0] cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_mode,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_mode,
    input  cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED cathode driver: per-channel OFF/ON/BLINK/PWM, runtime config port.
// Ports: clk, rst_n (sync, active low), cfg (slave), kled_tri (1 = lit), tick (prescaler pulse).
module led_pattern_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int PRESC_DIV   = 6000000,
  parameter int BLINK_TICKS = 4,
  parameter int PWM_W       = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  led_cfg_if.slave          cfg,
  output logic [NUM_CH-1:0] kled_tri,
  output logic              tick
);

  localparam int PR_W = $clog2(PRESC_DIV);
  localparam int BL_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PR_W-1:0] PR_LAST = PR_W'(PRESC_DIV - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_ON    = 2'd1,
    M_BLINK = 2'd2,
    M_PWM   = 2'd3
  } mode_e;

  // S_HOLD is the one dead cycle after reset or after an accept.
  typedef enum logic {
    S_HOLD = 1'b0,
    S_RDY  = 1'b1
  } cfg_st_e;

  logic [PR_W-1:0]   presc_q, presc_d;
  logic              tick_q, tick_d;
  logic [BL_W-1:0]   blink_q, blink_d;
  logic              phase_q, phase_d;
  logic [PWM_W-1:0]  pwm_q, pwm_d;
  mode_e             mode_q [NUM_CH];
  mode_e             mode_d [NUM_CH];
  logic [PWM_W-1:0]  duty_q [NUM_CH];
  logic [PWM_W-1:0]  duty_d [NUM_CH];
  logic [NUM_CH-1:0] kled_q, kled_d;
  cfg_st_e           st_q, st_d;

  logic wrap;
  logic accept;

  assign wrap   = (presc_q == PR_LAST);
  assign accept = cfg.cfg_valid && (st_q == S_RDY);

  assign cfg.cfg_ready = (st_q == S_RDY);
  assign kled_tri      = kled_q;
  assign tick          = tick_q;

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_HOLD: st_d = S_RDY;
      S_RDY:  st_d = accept ? S_HOLD : S_RDY;
      default: st_d = S_HOLD;
    endcase
  end

  always_comb begin
    presc_d = wrap ? '0 : presc_q + PR_W'(1);
    tick_d  = wrap;
    blink_d = blink_q;
    phase_d = phase_q;
    if (wrap) begin
      if (blink_q == BL_LAST) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BL_W'(1);
      end
    end
    pwm_d = pwm_q + PWM_W'(1);
  end

  // Out-of-range channels match no index, so they are silently dropped.
  always_comb begin
    mode_d = mode_q;
    duty_d = duty_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept && (cfg.cfg_ch == CH_W'(i))) begin
        mode_d[i] = mode_e'(cfg.cfg_mode);
        if (mode_e'(cfg.cfg_mode) == M_PWM) begin
          duty_d[i] = cfg.cfg_duty;
        end
      end
    end
  end

  // Output is taken from current state so a new mode shows one edge after accept.
  always_comb begin
    kled_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      unique case (mode_q[i])
        M_OFF:   kled_d[i] = 1'b0;
        M_ON:    kled_d[i] = 1'b1;
        M_BLINK: kled_d[i] = phase_q;
        M_PWM:   kled_d[i] = (pwm_q < duty_q[i]);
        default: kled_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      blink_q <= '0;
      phase_q <= 1'b0;
      pwm_q   <= '0;
      kled_q  <= '0;
      st_q    <= S_HOLD;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= M_OFF;
        duty_q[i] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      pwm_q   <= pwm_d;
      kled_q  <= kled_d;
      st_q    <= st_d;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= mode_d[i];
        duty_q[i] <= duty_d[i];
      end
    end
  end

endmodule
